sklansky_adder_pipe: RTL and testbench
======================================

// Module: sklansky_adder_pipe
// PURPOSE
//  Parametrised, pipelined Sklansky parallel-prefix adder/subtractor with valid/ready streaming.
//  Generalises the fixed 8-bit carry network to WIDTH bits, configurable pipeline cut points,
//  carry-in, subtract mode, carry-out and signed overflow. Sits in the ALU datapath in front
//  of the result mux.
// PARAMETERS
//  WIDTH      16  operand width; power of two, 2..64; LOG2W = clog2(WIDTH) prefix levels
//  REG_EVERY  2   register after every REG_EVERY prefix levels; 1..LOG2W
//  Latency L = 1 + ceil(LOG2W/REG_EVERY)  (W16/RE2 -> 3; W8/RE1 -> 4; W32/RE5 -> 2)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      pipe can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (use 1 with in_sub=1 for plain A-B)
//  in_sub     in   1      0: A+B+cin ; 1: A+~B+cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//  out_ovf    out  1      signed overflow = C[W-1]^C[W-2]
// BEHAVIOUR
//  - Reset: every stage valid bit 0, out_valid 0, out_sum/out_cout/out_ovf 0, in_ready 1 the
//    cycle after rst deasserts. rst mid-stream discards all in-flight beats; none emerge.
//  - Accept: beat taken when in_valid && in_ready. Stage 1 registers p=a^b', g=a&b',
//    cin and the valid bit (b' = in_sub ? ~in_b : in_b).
//  - Prefix: cin folded as bit -1: g0 := g0|(p0&cin). Level k (1..LOG2W) combines
//    span 2^(k-1): bits with bit (k-1) of index set take (G,P) from the top of the lower block
//    (grey cell if that source is already a final carry, else black cell). C[i] = G[i:0].
//  - Pipeline register inserted after level k when k%REG_EVERY==0 and k<LOG2W; final stage
//    registers sum[0]=p0^cin, sum[i]=p[i]^C[i-1], cout=C[W-1], ovf=C[W-1]^C[W-2].
//  - Flow control: global stall en = !(out_valid && !out_ready); in_ready = en. All stage
//    registers (data and valid) update only when en. Bubbles are not collapsed.
//  - Throughput 1 beat/clk when out_ready held 1; result of beat n appears exactly L cycles
//    after acceptance absent stalls; order strictly preserved, no loss, no duplication.
//  - out_* held stable while out_valid && !out_ready.
//  - in_valid && in_ready on the same cycle out_ready drops: beat accepted, pipe stalls next.
//  - Invalid stage data is don't-care but never X-propagates into valid beats.
// STRUCTURE
//  - Shared package sklansky_pkg: clog2 function, latency function
//    sklansky_latency(WIDTH,REG_EVERY), mode constants MODE_ADD=0/MODE_SUB=1.
//  - Sub-module sklansky_prefix_level #(WIDTH,LEVEL): combinational single prefix level
//    (G,P in -> G,P out) built from existing grey_box/black_box cells; top generates
//    LOG2W instances with conditional pipeline registers between them.
//  - Elaboration-time check: WIDTH power of two, REG_EVERY in range; else $error.
// TESTING
//  1 W16/RE2: A=FFFF B=0001 cin0 add -> sum 0000 cout1 ovf0, out_valid exactly 3 clk later.
//  2 W16: A=7FFF B=0001 add -> sum 8000 cout0 ovf1; A=0005 B=0007 sub cin1 -> FFFE cout0 ovf0.
//  3 Stream 1000 random beats, in_valid and out_ready randomly toggled -> outputs match
//    golden A+B'+cin in order, count equal, out_* stable during stalls.
//  4 rst asserted 1 cycle with 3 beats in flight -> no out_valid afterwards until new beats,
//    in_ready 1 the cycle after rst.
//  5 Param sweep W8/RE1 (L=4, exhaustive 2^17 add/sub vectors) and W32/RE5 (L=2) ->
//    zero mismatches, measured latency equals sklansky_latency().
//  6 out_ready held 0 for 10 cycles with full pipe -> in_ready 0, no beat accepted or
//    dropped; release -> L beats drain at 1/clk.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Shared definitions for the Sklansky prefix adder/subtractor pipeline:
// width helpers, latency calculation and add/subtract mode encoding.
package sklansky_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clock cycles from acceptance to result: the operand register plus one
    // register for every group of reg_every prefix levels (last group ends in
    // the output register).
    function automatic int sklansky_latency(input int width, input int reg_every);
        int levels;
        levels = clog2(width);
        return 1 + (levels + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/black_box.sv
// Black prefix cell: combines group generate and group propagate of two
// adjacent spans.
module black_box (
    input  logic gi,
    input  logic pi,
    input  logic gj,
    input  logic pj,
    output logic go,
    output logic po
);
    assign go = gi | (pi & gj);
    assign po = pi & pj;
endmodule

// File: rtl/grey_box.sv
// Grey prefix cell: the source is already a final carry, so only the group
// generate is needed.
module grey_box (
    input  logic gi,
    input  logic pi,
    input  logic gj,
    output logic go
);
    assign go = gi | (pi & gj);
endmodule

// File: rtl/sklansky_prefix_level.sv
// One combinational level of the Sklansky carry network. At level LEVEL every
// bit whose index has bit (LEVEL-1) set merges with the top bit of the block
// of 2^(LEVEL-1) bits directly below it; all other bits pass through.
module sklansky_prefix_level #(
    parameter int WIDTH = 16,
    parameter int LEVEL = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);
    localparam int SPAN = 1 << (LEVEL - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> (LEVEL - 1)) & 1) == 1) begin : g_merge
            localparam int J = ((i / SPAN) * SPAN) - 1;
            if (J < SPAN) begin : g_grey
                // Bits below SPAN are already complete carries (cin folded in).
                grey_box u_grey (
                    .gi(g_in[i]),
                    .pi(p_in[i]),
                    .gj(g_in[J]),
                    .go(g_out[i])
                );
                assign p_out[i] = p_in[i];
            end else begin : g_black
                black_box u_black (
                    .gi(g_in[i]),
                    .pi(p_in[i]),
                    .gj(g_in[J]),
                    .pj(p_in[J]),
                    .go(g_out[i]),
                    .po(p_out[i])
                );
            end
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end
endmodule

// File: rtl/sklansky_adder_pipe.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with valid/ready
// streaming. One global stall freezes every stage while the output beat is
// waiting for the consumer; bubbles travel with the data.
module sklansky_adder_pipe
    import sklansky_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int LOG2W = clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("sklansky_adder_pipe: WIDTH must be a power of two in 2..64");
    end
    if (REG_EVERY < 1 || REG_EVERY > LOG2W) begin : g_bad_reg_every
        $error("sklansky_adder_pipe: REG_EVERY must be in 1..clog2(WIDTH)");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign b_eff    = (in_sub == MODE_SUB) ? ~in_b : in_b;

    // Level k inputs (ig/ip), level k outputs (lg/lp) and the side-band
    // entering level k: original propagate (sp), carry-in (sc), valid (sv).
    // Index LOG2W+1 of the side-band feeds the output stage.
    logic [WIDTH-1:0] ig [1:LOG2W];
    logic [WIDTH-1:0] ip [1:LOG2W];
    logic [WIDTH-1:0] lg [1:LOG2W];
    logic [WIDTH-1:0] lp [1:LOG2W];
    logic [WIDTH-1:0] sp [1:LOG2W+1];
    logic             sc [1:LOG2W+1];
    logic             sv [1:LOG2W+1];

    // ---- stage p0: operand register (generate/propagate) ----
    logic [WIDTH-1:0] g_p0;
    logic [WIDTH-1:0] p_p0;
    logic             cin_p0;
    logic             vld_p0;

    // Valid bit of the operand stage; cleared by reset, frozen during stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
        end
    end

    // Operand stage data: bitwise generate/propagate against the effective B.
    always_ff @(posedge clk) begin
        if (en) begin
            g_p0   <= in_a & b_eff;
            p_p0   <= in_a ^ b_eff;
            cin_p0 <= in_cin;
        end
    end

    // Carry-in enters as bit -1, so bit 0 of G is a final carry immediately.
    assign ig[1] = {g_p0[WIDTH-1:1], g_p0[0] | (p_p0[0] & cin_p0)};
    assign ip[1] = p_p0;
    assign sp[1] = p_p0;
    assign sc[1] = cin_p0;
    assign sv[1] = vld_p0;

    for (genvar k = 1; k <= LOG2W; k++) begin : g_level
        sklansky_prefix_level #(
            .WIDTH(WIDTH),
            .LEVEL(k)
        ) u_level (
            .g_in (ig[k]),
            .p_in (ip[k]),
            .g_out(lg[k]),
            .p_out(lp[k])
        );

        if (k < LOG2W && (k % REG_EVERY) == 0) begin : g_cut
            // ---- stage boundary after prefix level k ----
            logic [WIDTH-1:0] g_pc;
            logic [WIDTH-1:0] p_pc;
            logic [WIDTH-1:0] s_pc;
            logic             cin_pc;
            logic             vld_pc;

            // Valid bit of this cut; cleared by reset, frozen during stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pc <= 1'b0;
                end else if (en) begin
                    vld_pc <= sv[k];
                end
            end

            // Partial prefix state and side-band carried across the cut.
            always_ff @(posedge clk) begin
                if (en) begin
                    g_pc   <= lg[k];
                    p_pc   <= lp[k];
                    s_pc   <= sp[k];
                    cin_pc <= sc[k];
                end
            end

            assign ig[k+1] = g_pc;
            assign ip[k+1] = p_pc;
            assign sp[k+1] = s_pc;
            assign sc[k+1] = cin_pc;
            assign sv[k+1] = vld_pc;
        end else begin : g_thru
            if (k < LOG2W) begin : g_next
                assign ig[k+1] = lg[k];
                assign ip[k+1] = lp[k];
            end
            assign sp[k+1] = sp[k];
            assign sc[k+1] = sc[k];
            assign sv[k+1] = sv[k];
        end
    end

    // ---- output stage: sum, carry-out, overflow ----
    logic [WIDTH-1:0] carry;
    assign carry = lg[LOG2W];

    // Result register; holds its beat while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            out_valid <= sv[LOG2W+1];
            out_sum   <= sp[LOG2W+1] ^ {carry[WIDTH-2:0], sc[LOG2W+1]};
            out_cout  <= carry[WIDTH-1];
            out_ovf   <= carry[WIDTH-1] ^ carry[WIDTH-2];
        end
    end

endmodule

// File: tb/tb_sklansky_adder_pipe.sv
// Directed bench for the Sklansky adder pipe: W16/RE2 main instance plus
// W8/RE1 and W32/RE5 instances for latency and boundary vectors.
module tb_sklansky_adder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // W16 / RE2
    logic        iv16 = 0, ir16, ic16 = 0, is16 = 0, ov16, or16 = 1, oc16, oo16;
    logic [15:0] ia16 = 0, ib16 = 0, os16;
    // W8 / RE1
    logic        iv8 = 0, ir8, ic8 = 0, is8 = 0, ov8, or8 = 1, oc8, oo8;
    logic [7:0]  ia8 = 0, ib8 = 0, os8;
    // W32 / RE5
    logic        iv32 = 0, ir32, ic32 = 0, is32 = 0, ov32, or32 = 1, oc32, oo32;
    logic [31:0] ia32 = 0, ib32 = 0, os32;

    sklansky_adder_pipe #(.WIDTH(16), .REG_EVERY(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(ia16), .in_b(ib16),
        .in_cin(ic16), .in_sub(is16), .out_valid(ov16), .out_ready(or16), .out_sum(os16),
        .out_cout(oc16), .out_ovf(oo16));

    sklansky_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(ia8), .in_b(ib8),
        .in_cin(ic8), .in_sub(is8), .out_valid(ov8), .out_ready(or8), .out_sum(os8),
        .out_cout(oc8), .out_ovf(oo8));

    sklansky_adder_pipe #(.WIDTH(32), .REG_EVERY(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(ia32), .in_b(ib32),
        .in_cin(ic32), .in_sub(is32), .out_valid(ov32), .out_ready(or32), .out_sum(os32),
        .out_cout(oc32), .out_ovf(oo32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat16(input string tag, input logic [15:0] a, b, input logic cin, sub,
                          input logic [15:0] es, input logic ec, eo);
        int n;
        @(posedge clk); #1;
        ia16 = a; ib16 = b; ic16 = cin; is16 = sub; iv16 = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            iv16 = 0;
            n++;
        end while (!ov16 && n < 20);
        chk({tag, " latency"}, n, 3);
        chk({tag, " sum"}, os16, es);
        chk({tag, " cout"}, oc16, ec);
        chk({tag, " ovf"}, oo16, eo);
    endtask

    task automatic beat8(input string tag, input logic [7:0] a, b, input logic cin, sub,
                         input logic [7:0] es, input logic ec, eo);
        int n;
        @(posedge clk); #1;
        ia8 = a; ib8 = b; ic8 = cin; is8 = sub; iv8 = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            iv8 = 0;
            n++;
        end while (!ov8 && n < 20);
        chk({tag, " latency"}, n, 4);
        chk({tag, " sum"}, os8, es);
        chk({tag, " cout"}, oc8, ec);
        chk({tag, " ovf"}, oo8, eo);
    endtask

    task automatic beat32(input string tag, input logic [31:0] a, b, input logic cin, sub,
                          input logic [31:0] es, input logic ec, eo);
        int n;
        @(posedge clk); #1;
        ia32 = a; ib32 = b; ic32 = cin; is32 = sub; iv32 = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            iv32 = 0;
            n++;
        end while (!ov32 && n < 20);
        chk({tag, " latency"}, n, 2);
        chk({tag, " sum"}, os32, es);
        chk({tag, " cout"}, oc32, ec);
        chk({tag, " ovf"}, oo32, eo);
    endtask

    // Four hand-computed add beats used for streaming, stall and reset steps.
    logic [15:0] sa [4];
    logic [15:0] sb [4];
    logic [15:0] se [4];
    logic        ce [4];
    logic        oe [4];

    // Scoreboard for the random stream: {ovf, cout, sum}.
    logic [17:0] expq [$];

    initial begin
        logic [16:0] full;
        logic [15:0] bb, held_sum;
        logic [17:0] got, want;
        logic        hold, accepted;
        int          sent, recv;

        sa[0] = 16'h0001; sb[0] = 16'h0002; se[0] = 16'h0003; ce[0] = 0; oe[0] = 0;
        sa[1] = 16'h1000; sb[1] = 16'h0100; se[1] = 16'h1100; ce[1] = 0; oe[1] = 0;
        sa[2] = 16'hFFFE; sb[2] = 16'h0003; se[2] = 16'h0001; ce[2] = 1; oe[2] = 0;
        sa[3] = 16'h4000; sb[3] = 16'h4000; se[3] = 16'h8000; ce[3] = 0; oe[3] = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset in_ready", ir16, 1);
        chk("reset out_valid", ov16, 0);
        chk("reset out_sum", os16, 0);
        chk("reset out_cout", oc16, 0);
        chk("reset out_ovf", oo16, 0);
        chk("reset out_valid w8", ov8, 0);
        chk("reset out_valid w32", ov32, 0);

        // Directed W16 vectors
        beat16("ffff+1", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        beat16("7fff+1", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        beat16("5-7", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
        beat16("5-7-1", 16'h0005, 16'h0007, 0, 1, 16'hFFFD, 0, 0);
        beat16("1234+4321", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
        beat16("8000+8000", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
        beat16("8000-1", 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1);
        beat16("00ff+cin", 16'h00FF, 16'h0000, 1, 0, 16'h0100, 0, 0);

        // Other parameterisations
        beat8("w8 ff+1", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
        beat8("w8 80-1", 8'h80, 8'h01, 1, 1, 8'h7F, 1, 1);
        beat8("w8 7f+7f", 8'h7F, 8'h7F, 0, 0, 8'hFE, 0, 1);
        beat32("w32 ffffffff+1", 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0);
        beat32("w32 7fffffff+1", 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
        beat32("w32 x-x", 32'h12345678, 32'h12345678, 1, 1, 32'h00000000, 1, 0);

        // Back-to-back stream: one result per clock, in order
        is16 = 0; ic16 = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 4) begin
                ia16 = sa[cyc]; ib16 = sb[cyc]; iv16 = 1;
            end else begin
                iv16 = 0;
            end
            if (cyc >= 3 && cyc <= 6) begin
                chk($sformatf("b2b valid %0d", cyc - 3), ov16, 1);
                chk($sformatf("b2b sum %0d", cyc - 3), os16, se[cyc - 3]);
                chk($sformatf("b2b cout %0d", cyc - 3), oc16, ce[cyc - 3]);
                chk($sformatf("b2b ovf %0d", cyc - 3), oo16, oe[cyc - 3]);
            end
        end
        @(posedge clk); #1;
        chk("b2b idle", ov16, 0);

        // Backpressure: fill the pipe, hold out_ready low for 10 cycles
        or16 = 0;
        for (int i = 0; i < 4; i++) begin
            ia16 = sa[i]; ib16 = sb[i]; iv16 = 1;
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall in_ready %0d", i), ir16, 0);
            chk($sformatf("stall valid %0d", i), ov16, 1);
            chk($sformatf("stall sum %0d", i), os16, se[0]);
            @(posedge clk); #1;
        end
        or16 = 1;
        chk("drain sum 0", os16, se[0]);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            iv16 = 0;
            chk($sformatf("drain valid %0d", i), ov16, 1);
            chk($sformatf("drain sum %0d", i), os16, se[i]);
        end
        @(posedge clk); #1;
        chk("drain idle", ov16, 0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            ia16 = sa[i]; ib16 = sb[i]; iv16 = 1;
            @(posedge clk); #1;
        end
        iv16 = 0;
        chk("preflush valid", ov16, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("flush in_ready", ir16, 1);
        chk("flush valid", ov16, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("flush quiet %0d", i), ov16, 0);
        end

        // Random stream with random backpressure against an arithmetic model
        sent = 0; recv = 0; hold = 0; accepted = 1; held_sum = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (accepted || !iv16) begin
                iv16 = ($urandom % 2) == 0;
                ia16 = 16'($urandom);
                ib16 = 16'($urandom);
                ic16 = 1'($urandom);
                is16 = 1'($urandom);
            end
            or16 = ($urandom % 4) != 0;
            @(negedge clk);
            if (hold) begin
                chk("hold valid", ov16, 1);
                chk("hold sum", os16, held_sum);
            end
            accepted = iv16 && ir16;
            if (accepted) begin
                bb   = is16 ? ~ib16 : ib16;
                full = {1'b0, ia16} + {1'b0, bb} + {16'd0, ic16};
                want = {(ia16[15] == bb[15]) && (full[15] != ia16[15]), full[16], full[15:0]};
                expq.push_back(want);
                sent++;
            end
            if (ov16 && or16) begin
                got = {oo16, oc16, os16};
                if (expq.size() == 0) begin
                    chk("stream unexpected beat", got, 18'h0);
                    chk("stream spurious", 1, 0);
                end else begin
                    want = expq.pop_front();
                    chk($sformatf("stream beat %0d", recv), got, want);
                end
                recv++;
            end
            hold = ov16 && !or16;
            held_sum = os16;
        end
        @(posedge clk); #1;
        iv16 = 0; or16 = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov16) begin
                got = {oo16, oc16, os16};
                if (expq.size() != 0) begin
                    want = expq.pop_front();
                    chk($sformatf("stream beat %0d", recv), got, want);
                end
                recv++;
            end
            @(posedge clk); #1;
        end
        chk("stream count", recv, sent);
        chk("stream leftover", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
